rcrc_reg: RTL and testbench
===========================

RCRC_REG -- requirements
Module: rcrc_reg

Interface
REQ-001 Parameter WIDTH, 15, CRC register width; 15, 17 and 21 supported.
REQ-002 Parameter POLY, 15'h4599, generator polynomial without the implicit top bit; WIDTH bits.
REQ-003 Parameter CNTW, 7, width of the bit counter.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  bit strobe; may stay high for several clocks; consumed once per rising edge of enable.
REQ-007 Input  input  1  received serial bit, sampled when a strobe is consumed.
REQ-008 start  input  1  single-cycle pulse starting a new frame.
REQ-009 check  input  1  single-cycle pulse marking the end of the CRC field.
REQ-010 crc  output  WIDTH  current CRC register.
REQ-011 crc_zero  output  1  high when crc == 0 and FSM is RUN or DONE.
REQ-012 crc_err  output  1  CRC error flag; timing per REQ-030.
REQ-013 bit_cnt  output  CNTW  number of bits consumed since start.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Edge detection: an internal flag SHALL set on the first clock with enable=1, and SHALL clear on a clock with enable=0.
REQ-016 A strobe is consumed only on a clock where enable=1, the flag is 0 and the FSM is RUN.
REQ-017 Holding enable high for N clocks SHALL consume exactly one bit.
REQ-018 Strobe update: nxt = Input XOR crc[WIDTH-1]; crc <= {crc[WIDTH-2:0],0} XOR (nxt ? POLY : 0).
REQ-019 Strobe update: bit_cnt increments by 1 and saturates at 2^CNTW-1 with no wrap.
REQ-020 start in any state SHALL clear crc and bit_cnt, clear crc_err, and enter RUN on the next clock.
REQ-021 When start and enable rise in the same clock, start wins and the bit is not consumed; the edge flag still sets.
REQ-022 check in RUN SHALL enter DONE and set crc_err = (crc != 0).
REQ-023 When check and a strobe coincide, the strobe SHALL be consumed first and check SHALL evaluate the updated crc; the result is visible the cycle after.
REQ-024 check in IDLE or DONE SHALL be ignored.
REQ-025 When start and check coincide, start wins.
REQ-026 In DONE, strobes are ignored and crc and bit_cnt hold; only start leaves DONE.
REQ-027 In IDLE, strobes are ignored.
REQ-028 The outputs crc, crc_zero and bit_cnt SHALL be registered or derived from registers only, with no combinational path from inputs.

Reset
REQ-029 Asserting reset SHALL immediately force: FSM to IDLE, crc=0, bit_cnt=0, crc_err=0, crc_zero=0, edge flag=0. Reset mid-frame discards the frame, and the block waits for start.

Configuration
REQ-030 Macro RCRC_STICKY_ERR_EN controls crc_err timing.
- Defined: crc_err is sticky from the evaluating check until the next start or reset.
- Undefined: crc_err is a one-clock pulse on the cycle after the evaluating check.

Structure
REQ-031 Package rcrc_pkg SHALL hold the state type (IDLE/RUN/DONE) and the CAN polynomial constants: CRC15 15'h4599, CRC17 17'h1685B, CRC21 21'h102899.
REQ-032 The edge detector SHALL be the sub-module rcrc_edge, with ports clock, reset, enable and a one-clock output strobe; the CRC datapath and FSM stay in rcrc_reg.

Verification
REQ-033 Reset, then check the outputs: IDLE, crc=0, crc_zero=0, crc_err=0, bit_cnt=0; enable toggling in IDLE leaves everything unchanged.
REQ-034 start, then one strobe with Input=1 -> crc=15'h4599, bit_cnt=1; a second strobe with Input=0 -> crc=15'h4EAB, bit_cnt=2.
REQ-035 start, then enable held high for 5 clocks with Input=1 -> exactly one update, crc=15'h4599, bit_cnt=1.
REQ-036 start, then bit 1 followed by the 15 bits of 15'h4599 MSB first, then check -> crc=0, crc_zero=1, crc_err=0, bit_cnt=16.
REQ-037 Same as REQ-036 but the last bit inverted, then check -> crc_err=1. With the macro: holds until start. Without: one-clock pulse.
REQ-038 Simultaneous events:
- start with enable rising -> bit dropped, bit_cnt=0.
- reset asserted mid-frame -> outputs zero asynchronously.
- 130 strobes with CNTW=7 -> bit_cnt saturates at 127.

Source files
------------

// File: rtl/rcrc_pkg.sv
// Shared types and constants for the serial CAN-style CRC checker.
// State encoding plus the standard CAN CRC-15/17/21 generator polynomials.
package rcrc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [14:0] CRC15 = 15'h4599;
    localparam logic [16:0] CRC17 = 17'h1685B;
    localparam logic [20:0] CRC21 = 21'h102899;

endpackage

// File: rtl/rcrc_if.sv
// Bundle of the serial-bit/control inputs and CRC status outputs of rcrc_reg.
// master drives the bit stream and pulses; slave is the CRC checker.
interface rcrc_if #(
    parameter int WIDTH = 15,
    parameter int CNTW  = 7
);
    logic             enable;
    logic             Input;
    logic             start;
    logic             check;
    logic [WIDTH-1:0] crc;
    logic             crc_zero;
    logic             crc_err;
    logic [CNTW-1:0]  bit_cnt;

    modport master (
        output enable, Input, start, check,
        input  crc, crc_zero, crc_err, bit_cnt
    );

    modport slave (
        input  enable, Input, start, check,
        output crc, crc_zero, crc_err, bit_cnt
    );
endinterface

// File: rtl/rcrc_edge.sv
// Rising-edge detector for the bit strobe: one pulse per high phase of enable,
// however many clocks enable stays high.
module rcrc_edge (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic strobe
);
    logic r_flag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= enable;
        end
    end

    assign strobe = enable & ~r_flag;

endmodule

// File: rtl/rcrc_reg.sv
// Serial CRC register with IDLE/RUN/DONE frame control and end-of-frame check.
// Define RCRC_STICKY_ERR_EN to hold crc_err until the next start; otherwise it pulses for one clock.
module rcrc_reg
    import rcrc_pkg::*;
#(
    parameter int               WIDTH = 15,
    parameter logic [WIDTH-1:0] POLY  = CRC15,
    parameter int               CNTW  = 7
) (
    input  logic  clock,
    input  logic  reset,
    rcrc_if.slave bus
);
    logic             w_strobe;
    logic             w_take;
    logic             w_nxt;
    logic [WIDTH-1:0] w_crc_shift;
    logic [WIDTH-1:0] w_crc_upd;
    logic [CNTW-1:0]  w_cnt_upd;

    state_t           r_state;
    logic [WIDTH-1:0] r_crc;
    logic [CNTW-1:0]  r_cnt;
    logic             r_err;

    rcrc_edge u_edge (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .strobe (w_strobe)
    );

    // start overrides everything in the FSM, so a strobe in the same clock is simply dropped there
    assign w_take      = w_strobe && (r_state == RUN);
    assign w_nxt       = bus.Input ^ r_crc[WIDTH-1];
    assign w_crc_shift = {r_crc[WIDTH-2:0], 1'b0} ^ (w_nxt ? POLY : '0);
    assign w_crc_upd   = w_take ? w_crc_shift : r_crc;
    assign w_cnt_upd   = (w_take && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_crc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (bus.start) begin
            r_state <= RUN;
            r_crc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
`ifndef RCRC_STICKY_ERR_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                RUN: begin
                    r_crc <= w_crc_upd;
                    r_cnt <= w_cnt_upd;
                    // check sees the crc including a coincident strobe
                    if (bus.check) begin
                        r_state <= DONE;
                        r_err   <= (w_crc_upd != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.crc      = r_crc;
    assign bus.crc_zero = (r_state != IDLE) && (r_crc == '0);
    assign bus.crc_err  = r_err;
    assign bus.bit_cnt  = r_cnt;

endmodule

// File: tb/tb_rcrc_reg.sv
// Self-checking bench for rcrc_reg: vector table plus hand-built frame sequences.
// Expected results are queued on drive and popped after the clock edge.
module tb_rcrc_reg;
    localparam int WIDTH = 15;
    localparam int CNTW  = 7;
`ifdef RCRC_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    typedef struct {
        logic             st;
        logic             en;
        logic             din;
        logic             chk;
        logic [WIDTH-1:0] crc;
        logic [CNTW-1:0]  cnt;
        logic             zero;
        logic             err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t exp_q[$];
    vec_t tbl[25];

    rcrc_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    rcrc_reg #(.WIDTH(WIDTH), .POLY(15'h4599), .CNTW(CNTW)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic st, logic en, logic din, logic chk,
                                logic [WIDTH-1:0] crc, logic [CNTW-1:0] cnt,
                                logic zero, logic err);
        vec_t v;
        v.st = st; v.en = en; v.din = din; v.chk = chk;
        v.crc = crc; v.cnt = cnt; v.zero = zero; v.err = err;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] crc_step(logic [WIDTH-1:0] c, logic b);
        logic n;
        n = b ^ c[WIDTH-1];
        return {c[WIDTH-2:0], 1'b0} ^ (n ? 15'h4599 : 15'h0000);
    endfunction

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void cmp_all(string tag, vec_t e);
        cmp({tag, " crc"},      32'(bus.crc),      32'(e.crc));
        cmp({tag, " bit_cnt"},  32'(bus.bit_cnt),  32'(e.cnt));
        cmp({tag, " crc_zero"}, 32'(bus.crc_zero), 32'(e.zero));
        cmp({tag, " crc_err"},  32'(bus.crc_err),  32'(e.err));
    endfunction

    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        bus.start  = v.st;
        bus.enable = v.en;
        bus.Input  = v.din;
        bus.check  = v.chk;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.check = 1'b0;
        e = exp_q.pop_front();
        $display("%s st=%b en=%b in=%b chk=%b -> crc=%h cnt=%0d zero=%b err=%b",
                 tag, v.st, v.en, v.din, v.chk, bus.crc, bus.bit_cnt, bus.crc_zero, bus.crc_err);
        cmp_all(tag, e);
    endtask

    initial begin
        logic [15:0]      frame;
        logic [WIDTH-1:0] c;
        logic [CNTW-1:0]  n;
        logic             b;
        vec_t             z;

        clk = 1'b0;
        rst_n = 1'b0;
        checks = 0;
        errors = 0;
        bus.enable = 1'b0;
        bus.Input  = 1'b0;
        bus.start  = 1'b0;
        bus.check  = 1'b0;

        z = mk(0, 0, 0, 0, 15'h0, 7'd0, 0, 0);
        #12;
        cmp_all("in_reset", z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        tbl[0]  = mk(0, 1, 1, 0, 15'h0000, 7'd0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 15'h0000, 7'd0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 15'h0000, 7'd0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 15'h0000, 7'd0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 15'h0000, 7'd0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 15'h0000, 7'd0, 1, 0);
        tbl[6]  = mk(0, 1, 1, 0, 15'h4599, 7'd1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 15'h4599, 7'd1, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 15'h4EAB, 7'd2, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 15'h4EAB, 7'd2, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 15'h0000, 7'd0, 1, 0);
        for (int i = 11; i < 16; i++)
            tbl[i] = mk(0, 1, 1, 0, 15'h4599, 7'd1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 15'h4599, 7'd1, 0, 0);
        tbl[17] = mk(1, 1, 1, 0, 15'h0000, 7'd0, 1, 0);
        tbl[18] = mk(0, 1, 1, 0, 15'h0000, 7'd0, 1, 0);
        tbl[19] = mk(0, 0, 1, 0, 15'h0000, 7'd0, 1, 0);
        tbl[20] = mk(0, 1, 1, 0, 15'h4599, 7'd1, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 15'h4599, 7'd1, 0, 0);
        tbl[22] = mk(1, 0, 0, 1, 15'h0000, 7'd0, 1, 0);
        tbl[23] = mk(0, 1, 1, 0, 15'h4599, 7'd1, 0, 0);
        tbl[24] = mk(0, 0, 0, 0, 15'h4599, 7'd1, 0, 0);

        for (int i = 0; i < 25; i++)
            apply($sformatf("tbl%0d", i), tbl[i]);

        // Good frame: bit 1 followed by its own CRC, check on a quiet cycle
        frame = {1'b1, 15'h4599};
        c = '0;
        apply("good_start", mk(1, 0, 0, 0, 15'h0, 7'd0, 1, 0));
        for (int i = 15; i >= 0; i--) begin
            b = frame[i];
            c = crc_step(c, b);
            apply($sformatf("good_bit%0d", 15 - i), mk(0, 1, b, 0, c, 7'(16 - i), c == '0, 0));
            apply($sformatf("good_low%0d", 15 - i), mk(0, 0, b, 0, c, 7'(16 - i), c == '0, 0));
        end
        apply("good_check", mk(0, 0, 0, 1, 15'h0000, 7'd16, 1, 0));
        apply("good_done_strobe", mk(0, 1, 1, 0, 15'h0000, 7'd16, 1, 0));
        apply("good_done_low", mk(0, 0, 0, 0, 15'h0000, 7'd16, 1, 0));

        // Bad frame: last bit inverted, check coincides with the final strobe
        frame[0] = ~frame[0];
        c = '0;
        apply("bad_start", mk(1, 0, 0, 0, 15'h0, 7'd0, 1, 0));
        for (int i = 15; i >= 1; i--) begin
            b = frame[i];
            c = crc_step(c, b);
            apply($sformatf("bad_bit%0d", 15 - i), mk(0, 1, b, 0, c, 7'(16 - i), c == '0, 0));
            apply($sformatf("bad_low%0d", 15 - i), mk(0, 0, b, 0, c, 7'(16 - i), c == '0, 0));
        end
        c = crc_step(c, frame[0]);
        cmp("bad_model_crc", 32'(c), 32'h4599);
        apply("bad_check", mk(0, 1, frame[0], 1, c, 7'd16, 0, 1));
        apply("bad_after1", mk(0, 0, 0, 0, c, 7'd16, 0, STICKY));
        apply("bad_done_strobe", mk(0, 1, 1, 0, c, 7'd16, 0, STICKY));
        apply("bad_done_check", mk(0, 0, 0, 1, c, 7'd16, 0, STICKY));
        apply("bad_after2", mk(0, 0, 0, 0, c, 7'd16, 0, STICKY));
        apply("bad_restart", mk(1, 0, 0, 0, 15'h0, 7'd0, 1, 0));

        // Saturation of the bit counter
        c = '0;
        n = '0;
        for (int i = 0; i < 130; i++) begin
            b = 1'(i % 3 == 0);
            c = crc_step(c, b);
            if (n != 7'd127) n = n + 7'd1;
            apply($sformatf("sat_bit%0d", i), mk(0, 1, b, 0, c, n, c == '0, 0));
            apply($sformatf("sat_low%0d", i), mk(0, 0, b, 0, c, n, c == '0, 0));
        end
        cmp("sat_final_cnt", 32'(bus.bit_cnt), 32'd127);

        // Asynchronous reset mid-frame
        apply("rst_start", mk(1, 0, 0, 0, 15'h0, 7'd0, 1, 0));
        apply("rst_bit", mk(0, 1, 1, 0, 15'h4599, 7'd1, 0, 0));
        apply("rst_low", mk(0, 0, 0, 0, 15'h4599, 7'd1, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        cmp_all("rst_async", z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply("rst_idle_strobe", mk(0, 1, 1, 0, 15'h0, 7'd0, 0, 0));
        apply("rst_idle_low", mk(0, 0, 0, 0, 15'h0, 7'd0, 0, 0));
        apply("rst_idle_check", mk(0, 0, 0, 1, 15'h0, 7'd0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
